// File: rtl/sump_pkg.sv
// Shared opcodes, trigger-stage register select and ID reply FSM states for the SUMP command path.
// Pure declarations: no latency, no backpressure.
package sump_pkg;

  localparam logic [7:0] OPC_RESET    = 8'h00;
  localparam logic [7:0] OPC_RUN      = 8'h01;
  localparam logic [7:0] OPC_ID       = 8'h02;
  localparam logic [7:0] OPC_XON      = 8'h11;
  localparam logic [7:0] OPC_XOFF     = 8'h13;
  localparam logic [7:0] OPC_DIV      = 8'h80;
  localparam logic [7:0] OPC_CNT      = 8'h81;
  localparam logic [7:0] OPC_FLAGS    = 8'h82;
  localparam logic [7:0] OPC_TRG_BASE = 8'hC0;
  localparam logic [7:0] OPC_TRG_MASK = 8'hF0;

  typedef enum logic [1:0] {
    STG_MASK   = 2'd0,
    STG_VALUE  = 2'd1,
    STG_CONFIG = 2'd2
  } stg_reg_e;

  typedef enum logic {
    ID_IDLE = 1'b0,
    ID_SEND = 1'b1
  } id_state_e;

endpackage

// File: rtl/sump_id_sender.sv
// Streams the ID word to the UART TX byte by byte, low byte first; first byte valid 1 cycle after start.
// Each byte is held with tx_stb high until tx_ack; abort drops the reply on the next edge.
module sump_id_sender
  import sump_pkg::*;
#(
  parameter int WORD_BITS = 8,
  parameter int CMD_WORDS = 4,
  parameter logic [WORD_BITS*CMD_WORDS-1:0] ID_WORD = 32'h534C_4131
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 tx_ack,
  output logic                 busy,
  output logic [WORD_BITS-1:0] tx_data,
  output logic                 tx_stb
);

  localparam int IDX_W = (CMD_WORDS > 1) ? $clog2(CMD_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CMD_WORDS - 1);

  id_state_e        state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ID_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Abort takes priority over a coincident ack so a soft reset always leaves the TX idle.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (abort) begin
      state_nx = ID_IDLE;
      idx_nx   = '0;
    end else begin
      case (state)
        ID_IDLE: begin
          if (start) begin
            state_nx = ID_SEND;
            idx_nx   = '0;
          end
        end
        ID_SEND: begin
          if (tx_ack) begin
            if (idx == IDX_LAST) begin
              state_nx = ID_IDLE;
              idx_nx   = '0;
            end else begin
              idx_nx = idx + 1'b1;
            end
          end
        end
        default: state_nx = ID_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_stb  = 1'b0;
    busy    = 1'b0;
    tx_data = '0;
    if (state == ID_SEND) begin
      tx_stb  = 1'b1;
      busy    = 1'b1;
      tx_data = ID_WORD[idx*WORD_BITS +: WORD_BITS];
    end
  end

endmodule

// File: rtl/sump_cmd_ctrl.sv
// Decodes SUMP commands into config registers, run/soft-reset pulses and the ID reply; all effects 1 cycle after stb_i.
// No backpressure on commands; the ID reply waits on tx_ack_i per byte.
module sump_cmd_ctrl
  import sump_pkg::*;
#(
  parameter int WORD_BITS  = 8,
  parameter int CMD_WORDS  = 4,
  parameter int TRG_STAGES = 4,
  parameter int DIV_BITS   = 24,
  parameter int CNT_BITS   = 16,
  parameter logic [WORD_BITS*CMD_WORDS-1:0] ID_WORD = 32'h534C_4131
) (
  input  logic                           clk_i,
  input  logic                           rst_in,
  input  logic [WORD_BITS-1:0]           opc_i,
  input  logic [WORD_BITS*CMD_WORDS-1:0] cmd_i,
  input  logic                           stb_i,
  output logic [DIV_BITS-1:0]            div_o,
  output logic [CNT_BITS-1:0]            read_cnt_o,
  output logic [CNT_BITS-1:0]            delay_cnt_o,
  output logic [WORD_BITS*CMD_WORDS-1:0] flags_o,
  output logic                           stg_we_o,
  output logic [1:0]                     stg_sel_o,
  output logic [1:0]                     stg_reg_o,
  output logic [WORD_BITS*CMD_WORDS-1:0] stg_data_o,
  output logic                           run_o,
  output logic                           soft_rst_o,
  output logic                           xoff_o,
  output logic                           busy_o,
  output logic [WORD_BITS-1:0]           tx_data_o,
  output logic                           tx_stb_o,
  input  logic                           tx_ack_i
);

  logic do_reset, do_run, do_id, do_xon, do_xoff;
  logic do_div, do_cnt, do_flags, do_trg;

  assign do_reset = stb_i && (opc_i == OPC_RESET);
  assign do_run   = stb_i && (opc_i == OPC_RUN);
  assign do_id    = stb_i && (opc_i == OPC_ID);
  assign do_xon   = stb_i && (opc_i == OPC_XON);
  assign do_xoff  = stb_i && (opc_i == OPC_XOFF);
  assign do_div   = stb_i && (opc_i == OPC_DIV);
  assign do_cnt   = stb_i && (opc_i == OPC_CNT);
  assign do_flags = stb_i && (opc_i == OPC_FLAGS);
  // Register select 3 and stages beyond the configured count are silently dropped.
  assign do_trg   = stb_i && ((opc_i & OPC_TRG_MASK) == OPC_TRG_BASE)
                    && (opc_i[1:0] <= 2'(STG_CONFIG))
                    && (int'(opc_i[3:2]) < TRG_STAGES);

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      div_o       <= '0;
      read_cnt_o  <= '0;
      delay_cnt_o <= '0;
      flags_o     <= '0;
      stg_we_o    <= 1'b0;
      stg_sel_o   <= '0;
      stg_reg_o   <= '0;
      stg_data_o  <= '0;
      run_o       <= 1'b0;
      soft_rst_o  <= 1'b0;
      xoff_o      <= 1'b0;
    end else begin
      run_o      <= do_run;
      soft_rst_o <= do_reset;
      stg_we_o   <= do_trg;
      if (do_reset) begin
        div_o       <= '0;
        read_cnt_o  <= '0;
        delay_cnt_o <= '0;
        flags_o     <= '0;
        xoff_o      <= 1'b0;
      end else begin
        if (do_xon)   xoff_o <= 1'b0;
        if (do_xoff)  xoff_o <= 1'b1;
        if (do_div)   div_o  <= cmd_i[DIV_BITS-1:0];
        if (do_cnt) begin
          read_cnt_o  <= cmd_i[CNT_BITS-1:0];
          delay_cnt_o <= cmd_i[CNT_BITS +: CNT_BITS];
        end
        if (do_flags) flags_o <= cmd_i;
      end
      // Stage address/data hold after the pulse so the owner can sample late.
      if (do_trg) begin
        stg_sel_o  <= opc_i[3:2];
        stg_reg_o  <= opc_i[1:0];
        stg_data_o <= cmd_i;
      end
    end
  end

  sump_id_sender #(
    .WORD_BITS (WORD_BITS),
    .CMD_WORDS (CMD_WORDS),
    .ID_WORD   (ID_WORD)
  ) u_id_sender (
    .clk     (clk_i),
    .rst_n   (rst_in),
    .start   (do_id),
    .abort   (do_reset),
    .tx_ack  (tx_ack_i),
    .busy    (busy_o),
    .tx_data (tx_data_o),
    .tx_stb  (tx_stb_o)
  );

endmodule

// File: doc/sump_cmd_ctrl.md
Name: sump_cmd_ctrl

Overview:
- Command controller sitting directly behind the UART receiver in the logic analyzer.
- Consumes decoded SUMP commands (opcode plus 32-bit argument, one strobe per command).
- Updates the configuration registers for divider, counters and trigger stages, and issues run/soft-reset pulses.
- Sequences the 4-byte ID reply into the UART transmitter through a valid/ack handshake.

Parameters:
- WORD_BITS, 8, bits per UART word; also the width of opcode and TX data.
- CMD_WORDS, 4, argument words per long command; argument width CMD_W = WORD_BITS*CMD_WORDS.
- TRG_STAGES, 4, number of trigger stages; must be at most 4.
- DIV_BITS, 24, sample divider width.
- CNT_BITS, 16, read and delay counter width.
- ID_WORD, 32'h534C_4131, ID reply ("1ALS"); sent byte [7:0] first.

Ports:
- clk_i  in  1  system clock.
- rst_in  in  1  reset, synchronous, active-low.
- opc_i  in  WORD_BITS  command opcode; valid when stb_i=1.
- cmd_i  in  CMD_W  command argument, little-endian; valid when stb_i=1.
- stb_i  in  1  single-cycle command strobe.
- div_o  out  DIV_BITS  sample divider.
- read_cnt_o  out  CNT_BITS  read count.
- delay_cnt_o  out  CNT_BITS  delay count.
- flags_o  out  CMD_W  raw flags register.
- stg_we_o  out  1  trigger-stage write pulse.
- stg_sel_o  out  2  stage index.
- stg_reg_o  out  2  register select: 0=mask, 1=value, 2=config.
- stg_data_o  out  CMD_W  stage write data.
- run_o  out  1  arm pulse.
- soft_rst_o  out  1  soft reset pulse.
- xoff_o  out  1  flow-control pause level.
- busy_o  out  1  ID reply in progress.
- tx_data_o  out  WORD_BITS  byte to transmit.
- tx_stb_o  out  1  TX valid.
- tx_ack_i  in  1  TX accepted the byte.

Behaviour:
- Reset (rst_in=0 at a clk_i edge): every output is 0, the FSM returns to IDLE and the byte index is 0.
- All decode is registered. An effect of a command at stb_i in cycle N is visible at cycle N+1. Pulse outputs are exactly 1 cycle wide.
- opc_i is ignored when stb_i=0.

Short commands (opc_i[7]=0, cmd_i ignored):
- 0x00 soft reset:
  - Pulses soft_rst_o.
  - Clears div_o, read_cnt_o, delay_cnt_o, flags_o and xoff_o.
  - Aborts any ID reply: tx_stb_o drops at N+1, FSM goes to IDLE.
  - Trigger stages are reset by their owner via soft_rst_o, not by stage writes.
- 0x01 arm: pulses run_o.
- 0x02 ID: starts the ID reply if the FSM is IDLE; ignored while busy_o=1.
- 0x11 XON: clears xoff_o.
- 0x13 XOFF: sets xoff_o.
- Any other short opcode: no effect.

Long commands (opc_i[7]=1):
- 0x80: div_o <= cmd_i[DIV_BITS-1:0].
- 0x81: read_cnt_o <= cmd_i[15:0], delay_cnt_o <= cmd_i[31:16].
- 0x82: flags_o <= cmd_i.
- 0xC0..0xCF: stage = opc_i[3:2], reg = opc_i[1:0].
  - If reg<3 and stage<TRG_STAGES: pulse stg_we_o with stg_sel_o, stg_reg_o and stg_data_o=cmd_i. These three hold their value until the next write.
  - Otherwise: no effect.
- Other long opcodes: no effect.

ID FSM (IDLE, SEND):
- IDLE -> SEND on accepted 0x02. Sets index=0, tx_data_o=ID_WORD[7:0], tx_stb_o=1, busy_o=1.
- In SEND, tx_stb_o and tx_data_o stay stable until a cycle with tx_ack_i=1.
- On tx_ack_i=1 with index<3: index+1, next byte presented at the following cycle, tx_stb_o stays 1.
- On tx_ack_i=1 with index=3: tx_stb_o=0, busy_o=0, back to IDLE.
- tx_ack_i is ignored when tx_stb_o=0.
- Soft reset in SEND aborts the reply. A byte already acked is not recalled.

Concurrency:
- Config and arm commands are processed while SEND is active.
- Simultaneous tx_ack_i and a 0x00 strobe: the abort wins.
- xoff_o does not gate the ID reply; gating is the transmitter's concern.

Decomposition:
- Package sump_pkg: opcode constants (OPC_RESET, OPC_RUN, OPC_ID, OPC_XON, OPC_XOFF, OPC_DIV, OPC_CNT, OPC_FLAGS, OPC_TRG_BASE), the stage register enum (mask/value/config) and the ID FSM state enum.
- One sub-module is natural: sump_id_sender, holding the ID FSM and TX handshake, with start/abort inputs.

Test Plan:
- Reset with stb_i idle -> every output is 0 at the first cycle after reset.
- opc=0x80, cmd=0x00123456 -> div_o=0x123456 one cycle later. Then opc=0x81, cmd=0x00400100 -> read_cnt_o=0x0100, delay_cnt_o=0x0040.
- opc=0xC5, cmd=0xDEADBEEF -> single stg_we_o pulse with stg_sel_o=1, stg_reg_o=1, stg_data_o=0xDEADBEEF. opc=0xC3 -> no pulse.
- opc=0x02, ack delayed 0/3/1/5 cycles per byte -> tx_data_o sequence 0x31, 0x41, 0x4C, 0x53, stable while tx_stb_o is high. busy_o falls after the 4th ack. A second 0x02 mid-reply is ignored.
- ID reply after the 2nd byte acked, then opc=0x00 -> soft_rst_o pulse, tx_stb_o=0, div_o/read_cnt_o/xoff_o cleared. A new 0x02 restarts from 0x31.
- opc=0x13 then 0x01 -> xoff_o=1 and a run_o pulse. Then opc=0x11 -> xoff_o=0. Reset asserted mid-SEND -> all outputs 0 at the next edge.
